// File: rtl/mem_port_if.sv
// Memory-side request/response bus shared by the arbiter (master) and the
// single-ported unified memory (slave).
interface mem_port_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m_valid;
    logic          m_ready;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_wdata,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_wdata,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between fetch (IF) and
// load/store (MEM), one transaction at a time, and generates pipeline stalls.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    output logic          stall_if,
    output logic          stall_pipe,
    mem_port_if.master    bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {GNT_IF = 1'b0, GNT_MEM = 1'b1} gnt_t;

    state_t state, state_next;
    gnt_t   gnt, gnt_next;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        unique case (state)
            IDLE: begin
                // MEM is the older instruction, so it always wins.
                if (mem_rd || mem_wr) begin
                    gnt_next   = GNT_MEM;
                    state_next = ISSUE;
                end else if (if_req) begin
                    gnt_next   = GNT_IF;
                    state_next = ISSUE;
                end
            end
            ISSUE: if (bus.m_ready) state_next = bus.m_we ? DONE : WAIT;
            WAIT:  if (bus.m_rvalid) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= GNT_IF;
            bus.m_valid <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
        end else begin
            state       <= state_next;
            gnt         <= gnt_next;
            bus.m_valid <= (state_next == ISSUE);
            if_done     <= (state_next == DONE) && (gnt_next == GNT_IF);
            mem_done    <= (state_next == DONE) && (gnt_next == GNT_MEM);

            // Request fields are frozen at grant; mem_rd&mem_wr resolves to a write.
            if (state == IDLE && state_next == ISSUE) begin
                if (gnt_next == GNT_MEM) begin
                    bus.m_we    <= mem_wr;
                    bus.m_addr  <= mem_addr;
                    bus.m_wdata <= mem_wdata;
                end else begin
                    bus.m_we   <= 1'b0;
                    bus.m_addr <= if_addr;
                end
            end

            if (state == WAIT && bus.m_rvalid) begin
                if (gnt == GNT_IF) if_rdata  <= bus.m_rdata;
                else               mem_rdata <= bus.m_rdata;
            end
        end
    end

    assign stall_pipe = (mem_rd | mem_wr) & ~mem_done;
    assign stall_if   = (if_req & ~if_done) | stall_pipe;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store driven by the EX→MEM pipeline register outputs). It runs one memory transaction at a time through a valid/ready request channel and a valid-only read-response channel. It returns fetched instructions and load data, and generates the stall signals that freeze the PC and pipeline registers while an access is outstanding.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  AW  fetch address; stable while if_req high
- if_rdata  out  DW  fetched instruction; valid when if_done=1, held until next fetch completion
- if_done  out  1  one-cycle fetch completion pulse
- mem_rd  in  1  load in MEM stage; held until mem_done
- mem_wr  in  1  store in MEM stage (memWr of MEM stage); held until mem_done
- mem_addr  in  AW  load/store address (ALU result of MEM stage)
- mem_wdata  in  DW  store data
- mem_rdata  out  DW  load data; valid when mem_done=1, held until next load completion
- mem_done  out  1  one-cycle load/store completion pulse
- stall_if  out  1  freeze PC and IF/ID
- stall_pipe  out  1  freeze IF/ID, ID/EX and EX/MEM and the PC
- m_valid  out  1  memory request valid
- m_ready  in  1  memory accepts request when m_valid&m_ready
- m_we  out  1  request is a write
- m_addr  out  AW  request address
- m_wdata  out  DW  write data
- m_rvalid  in  1  read response valid
- m_rdata  in  DW  read response data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Grant register gnt (0=IF, 1=MEM) and op register (read/write) are latched on leaving IDLE.
- IDLE: if mem_rd|mem_wr, then gnt=MEM and go to ISSUE. Otherwise, if if_req, then gnt=IF and go to ISSUE. Otherwise stay in IDLE.
- MEM has fixed priority over IF because it is the older instruction. IF cannot starve: the pipeline drains while IF is stalled.
- mem_rd and mem_wr both high is illegal. It is treated as a write.
- ISSUE: m_valid=1. m_addr, m_we and m_wdata come from registers latched at grant and stay stable until handshake.
  - On m_valid&m_ready: a write goes to DONE; a read goes to WAIT.
- WAIT: on m_rvalid, capture m_rdata into if_rdata or mem_rdata (per gnt) and go to DONE.
- DONE: for one cycle, assert if_done or mem_done (per gnt), then go to IDLE. The requester sees the pipeline advance in this cycle and presents its next request from the following cycle.
- m_rvalid outside WAIT is ignored.
- stall_pipe = (mem_rd|mem_wr) & ~mem_done.
- stall_if = (if_req & ~if_done) | stall_pipe.
- When only IF is pending, downstream registers are not frozen; bubble insertion is the pipeline's job.

## Timing
- All outputs except stall_if and stall_pipe are registered. The stalls are combinational from requests and registered done flags.
- Minimum latency, request first seen in IDLE at cycle 0:
  - m_valid rises in cycle 1.
  - Write accepted in cycle 1 gives done in cycle 2.
  - Read accepted in cycle 1 with m_rvalid in cycle 2 gives done in cycle 3.
- m_rvalid arrives no earlier than the cycle after acceptance.
- m_ready low holds ISSUE indefinitely with outputs stable.
- m_rvalid low holds WAIT indefinitely.
- Back-to-back: after DONE, the next grant is taken in IDLE one cycle later. Throughput is at most one access per 3 cycles for writes and 4 cycles for reads.
- Requests arriving while not in IDLE are not sampled until the FSM returns to IDLE.
- Reset values: state=IDLE, gnt=IF, m_valid=0, m_we=0, m_addr=0, m_wdata=0, if_done=0, mem_done=0, if_rdata=0, mem_rdata=0.
- Reset asserted mid-transaction aborts it immediately with outputs at reset values. A memory response arriving after reset release is dropped in IDLE.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, m_ready=1, m_rvalid one cycle after accept with m_rdata=0x2402000A. Required: m_valid in cycle 1 with m_we=0; if_done pulse in cycle 3 with if_rdata=0x2402000A; stall_pipe=0 throughout.
- Store: mem_wr=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, m_ready low 2 cycles. Required: m_valid held 3 cycles with stable address and data; m_we=1; mem_done exactly one cycle after accept; stall_pipe high until the done cycle.
- Simultaneous: if_req and mem_rd both high in IDLE. Required: load served first, then fetch; stall_if high until if_done; stall_pipe low from the mem_done cycle.
- Slow read: m_rvalid delayed 5 cycles; spurious m_rvalid while in IDLE. Required: done exactly one cycle after the real m_rvalid; the spurious response leaves rdata unchanged.
- Reset mid-WAIT. Required: m_valid=0, done=0, rdata=0 immediately; the late m_rvalid is ignored; a normal fetch completes afterward.
- Back-to-back stores with the request held across done. Required: exactly one mem_done per store; the second m_valid appears 2 cycles after the first mem_done.
